prm_edge_mask_engine: RTL and testbench
=======================================

PRM_EDGE_MASK_ENGINE -- requirements
Module: prm_edge_mask_engine
Interface
REQ-001 Parameter NUM_IN, default 15, number of obstacle/joint predicate input bits per query.
REQ-002 Parameter NUM_EDGES, default 1024, number of roadmap edges with a programmable mask function.
REQ-003 Parameter MAX_TERMS, default 256, maximum product terms per edge.
REQ-004 Ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-005 cfg_valid in 1; cfg_ready out 1; cfg_kind in 1 (0 = term word, 1 = term count); cfg_edge in clog2(NUM_EDGES); cfg_term in clog2(MAX_TERMS); cfg_data in 2*NUM_IN, {care[NUM_IN-1:0], value[NUM_IN-1:0]} or zero-extended count.
REQ-006 q_valid in 1; q_ready out 1; q_edge in clog2(NUM_EDGES); q_vec in NUM_IN, predicate vector, bit 0 = A.
REQ-007 r_valid out 1; r_ready in 1; r_mask out 1, edge_mask result; r_term out clog2(MAX_TERMS), index of first matching term (0 when r_mask = 0).
Function
REQ-008 Each edge SHALL hold N(e) in 0..MAX_TERMS terms; edge_mask = OR over i<N(e) of (((q_vec ^ value_i) & care_i) == 0).
REQ-009 A term with care = 0 SHALL always match; count values above MAX_TERMS SHALL saturate to MAX_TERMS.
REQ-010 FSM states IDLE, FETCH, EVAL, RESP; reset state IDLE.
REQ-011 IDLE: cfg_ready = q_ready = 1; a query transfer (q_valid & q_ready) SHALL latch q_edge/q_vec and go to FETCH; a simultaneous cfg transfer SHALL take priority and the query SHALL NOT be accepted that cycle.
REQ-012 cfg_ready and q_ready SHALL be 0 in FETCH, EVAL, RESP; configuration is never modified mid-query.
REQ-013 FETCH: read count N(e) and term 0 (1-cycle synchronous RAM); N = 0 SHALL go to RESP with r_mask = 0.
REQ-014 EVAL: compare one term per cycle, prefetching term i+1; first hit SHALL go to RESP with r_mask = 1, r_term = i (early exit); last term missed SHALL go to RESP with r_mask = 0.
REQ-015 Latency, query accepted in cycle t: term i compared in cycle t+2+i; r_valid first high in t+3+i on hit at i, t+2+N on miss, t+2 when N = 0.
REQ-016 RESP: r_valid = 1 with r_mask/r_term stable until r_valid & r_ready, then IDLE; next query accepted no earlier than the following cycle.
REQ-017 A cfg write in cycle t SHALL be visible to a query accepted in cycle t+1 or later.
REQ-018 Out-of-range q_edge/cfg_edge (>= NUM_EDGES) SHALL be accepted; query returns r_mask = 0, cfg write is dropped.
Reset
REQ-019 rst_n low SHALL asynchronously force IDLE, r_valid = 0, r_mask = 0, r_term = 0, cfg_ready = 0, q_ready = 0; any in-flight query is discarded.
REQ-020 All count entries SHALL read 0 after reset (per-edge valid bit cleared); term RAM contents are undefined and not reset.
REQ-021 Ready outputs SHALL assert in the first clk cycle after rst_n deasserts.
Structure
REQ-022 Package prm_mask_pkg SHALL hold default parameters, the FSM state enum, and the term-word struct {care, value}.
REQ-023 Term storage SHALL be the sub-module prm_term_ram (single-port synchronous, depth NUM_EDGES*MAX_TERMS, width 2*NUM_IN, address {edge, term}).
REQ-024 Counts SHALL live in a separate register array with per-edge valid bits.
Verification
REQ-025 Reset then query edge 5, q_vec = 0 -> r_mask = 0, r_valid in cycle t+2.
REQ-026 Edge 3, N = 2, term0 care 0x0001 value 0x0000, term1 care 0x4000 value 0x4000; q_vec = 0x4001 -> r_mask = 1, r_term = 1, r_valid at t+4.
REQ-027 Edge 7 programmed with the 15-input reference SOP (213 terms); 10k random q_vec -> r_mask equals golden model, latency per REQ-015.
REQ-028 Hold r_ready = 0 for 5 cycles in RESP -> r_mask/r_term stable, q_ready = 0, cfg_ready = 0.
REQ-029 cfg_valid and q_valid together in IDLE -> cfg written, query accepted next cycle and sees new data.
REQ-030 Assert rst_n low during EVAL of a 200-term edge -> r_valid = 0 immediately, counts read 0 after release.

Source files
------------

// File: rtl/prm_mask_pkg.sv
// Shared defaults, FSM state encoding and term-word layout for the PRM edge mask engine.
package prm_mask_pkg;

    localparam int unsigned DEF_NUM_IN    = 15;
    localparam int unsigned DEF_NUM_EDGES = 1024;
    localparam int unsigned DEF_MAX_TERMS = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EVAL  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // One product term: a predicate bit participates only where care is set.
    typedef struct packed {
        logic [DEF_NUM_IN-1:0] care;
        logic [DEF_NUM_IN-1:0] value;
    } term_t;

endpackage

// File: rtl/prm_edge_mask_engine_if.sv
// Configuration, query and response channels of the PRM edge mask engine.
interface prm_edge_mask_engine_if
    import prm_mask_pkg::*;
#(
    parameter int unsigned NUM_IN    = DEF_NUM_IN,
    parameter int unsigned NUM_EDGES = DEF_NUM_EDGES,
    parameter int unsigned MAX_TERMS = DEF_MAX_TERMS
);
    localparam int unsigned EW = $clog2(NUM_EDGES);
    localparam int unsigned TW = $clog2(MAX_TERMS);

    logic                cfg_valid;
    logic                cfg_ready;
    logic                cfg_kind;
    logic [EW-1:0]       cfg_edge;
    logic [TW-1:0]       cfg_term;
    logic [2*NUM_IN-1:0] cfg_data;

    logic                q_valid;
    logic                q_ready;
    logic [EW-1:0]       q_edge;
    logic [NUM_IN-1:0]   q_vec;

    logic                r_valid;
    logic                r_ready;
    logic                r_mask;
    logic [TW-1:0]       r_term;

    modport master (
        output cfg_valid, cfg_kind, cfg_edge, cfg_term, cfg_data,
        input  cfg_ready,
        output q_valid, q_edge, q_vec,
        input  q_ready,
        input  r_valid, r_mask, r_term,
        output r_ready
    );

    modport slave (
        input  cfg_valid, cfg_kind, cfg_edge, cfg_term, cfg_data,
        output cfg_ready,
        input  q_valid, q_edge, q_vec,
        output q_ready,
        output r_valid, r_mask, r_term,
        input  r_ready
    );

endinterface

// File: rtl/prm_term_ram.sv
// Single-port synchronous term store, addressed {edge, term}; contents are not reset.
module prm_term_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 30
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Read-before-write port; read data appears one cycle after the address.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/prm_edge_mask_engine.sv
// Evaluates a per-edge sum-of-products mask over a predicate vector, one term per cycle.
module prm_edge_mask_engine
    import prm_mask_pkg::*;
#(
    parameter int unsigned NUM_IN    = DEF_NUM_IN,
    parameter int unsigned NUM_EDGES = DEF_NUM_EDGES,
    parameter int unsigned MAX_TERMS = DEF_MAX_TERMS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prm_edge_mask_engine_if.slave bus
);

    localparam int unsigned EW = $clog2(NUM_EDGES);
    localparam int unsigned TW = $clog2(MAX_TERMS);
    localparam int unsigned CW = $clog2(MAX_TERMS + 1);
    localparam int unsigned DW = 2 * NUM_IN;
    localparam int unsigned AW = EW + TW;

    state_t            state, state_nx;
    logic [EW-1:0]     edge_q, edge_nx;
    logic [NUM_IN-1:0] vec_q, vec_nx;
    logic [TW-1:0]     term_q, term_nx;
    logic [CW-1:0]     cnt_q, cnt_nx;
    logic              r_valid_q;
    logic              r_mask_q, r_mask_nx;
    logic [TW-1:0]     r_term_q, r_term_nx;
    logic              cfg_ready_q, q_ready_q;

    logic [NUM_EDGES-1:0] cnt_vld;
    logic [CW-1:0]        cnt_mem [NUM_EDGES];
    logic                 cnt_we;
    logic [CW-1:0]        cnt_wdata, cnt_rd;

    logic              ram_en, ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_rdata;
    logic [NUM_IN-1:0] ram_care, ram_value;

    logic cfg_fire, q_fire, cfg_edge_ok, q_edge_ok, hit, last;

    // Configuration wins over a query offered in the same cycle.
    assign cfg_fire    = bus.cfg_valid & cfg_ready_q;
    assign q_fire      = bus.q_valid & q_ready_q & ~bus.cfg_valid;
    assign cfg_edge_ok = (EW+1)'(bus.cfg_edge) < (EW+1)'(NUM_EDGES);
    assign q_edge_ok   = (EW+1)'(edge_q) < (EW+1)'(NUM_EDGES);

    assign cnt_wdata = (bus.cfg_data > DW'(MAX_TERMS)) ? CW'(MAX_TERMS) : CW'(bus.cfg_data);
    assign cnt_rd    = (q_edge_ok && cnt_vld[edge_q]) ? cnt_mem[edge_q] : '0;

    assign ram_care  = ram_rdata[DW-1:NUM_IN];
    assign ram_value = ram_rdata[NUM_IN-1:0];
    assign hit       = ((vec_q ^ ram_value) & ram_care) == '0;
    assign last      = (CW'(term_q) + CW'(1)) == cnt_q;

    prm_term_ram #(
        .DEPTH (NUM_EDGES * MAX_TERMS),
        .AW    (AW),
        .DW    (DW)
    ) u_term_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus.cfg_data),
        .rdata (ram_rdata)
    );

    // Next-state, datapath and storage-port control.
    always_comb begin
        state_nx  = state;
        edge_nx   = edge_q;
        vec_nx    = vec_q;
        term_nx   = term_q;
        cnt_nx    = cnt_q;
        r_mask_nx = r_mask_q;
        r_term_nx = r_term_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {edge_q, term_q};
        cnt_we    = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_fire) begin
                    if (cfg_edge_ok) begin
                        if (!bus.cfg_kind) begin
                            ram_en   = 1'b1;
                            ram_we   = 1'b1;
                            ram_addr = {bus.cfg_edge, bus.cfg_term};
                        end else begin
                            cnt_we = 1'b1;
                        end
                    end
                end else if (q_fire) begin
                    edge_nx  = bus.q_edge;
                    vec_nx   = bus.q_vec;
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                ram_en   = 1'b1;
                ram_addr = {edge_q, TW'(0)};
                term_nx  = '0;
                cnt_nx   = cnt_rd;
                if (cnt_rd == '0) begin
                    r_mask_nx = 1'b0;
                    r_term_nx = '0;
                    state_nx  = RESP;
                end else begin
                    state_nx = EVAL;
                end
            end
            EVAL: begin
                ram_en   = 1'b1;
                ram_addr = {edge_q, term_q + TW'(1)};
                if (hit) begin
                    r_mask_nx = 1'b1;
                    r_term_nx = term_q;
                    state_nx  = RESP;
                end else if (last) begin
                    r_mask_nx = 1'b0;
                    r_term_nx = '0;
                    state_nx  = RESP;
                end else begin
                    term_nx = term_q + TW'(1);
                end
            end
            RESP: begin
                if (bus.r_ready && r_valid_q) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, query context and registered outputs; reset discards any query in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            edge_q      <= '0;
            vec_q       <= '0;
            term_q      <= '0;
            cnt_q       <= '0;
            r_valid_q   <= 1'b0;
            r_mask_q    <= 1'b0;
            r_term_q    <= '0;
            cfg_ready_q <= 1'b0;
            q_ready_q   <= 1'b0;
        end else begin
            state       <= state_nx;
            edge_q      <= edge_nx;
            vec_q       <= vec_nx;
            term_q      <= term_nx;
            cnt_q       <= cnt_nx;
            r_valid_q   <= (state_nx == RESP);
            r_mask_q    <= r_mask_nx;
            r_term_q    <= r_term_nx;
            cfg_ready_q <= (state_nx == IDLE);
            q_ready_q   <= (state_nx == IDLE);
        end
    end

    // Per-edge count-valid bits; clearing them makes every count read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_vld <= '0;
        end else if (cnt_we) begin
            cnt_vld[bus.cfg_edge] <= 1'b1;
        end
    end

    // Saturated term counts, qualified by cnt_vld.
    always_ff @(posedge clk) begin
        if (cnt_we) begin
            cnt_mem[bus.cfg_edge] <= cnt_wdata;
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.q_ready   = q_ready_q;
    assign bus.r_valid   = r_valid_q;
    assign bus.r_mask    = r_mask_q;
    assign bus.r_term    = r_term_q;

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Randomized scoreboard bench for prm_edge_mask_engine against a behavioural SOP model.
module tb_prm_edge_mask_engine;
    import prm_mask_pkg::*;

    localparam int unsigned NI = DEF_NUM_IN;
    localparam int unsigned NE = DEF_NUM_EDGES;
    localparam int unsigned MT = DEF_MAX_TERMS;
    localparam int unsigned EW = $clog2(NE);
    localparam int unsigned TW = $clog2(MT);
    localparam int unsigned DW = 2 * NI;
    localparam int          BUDGET = 2000;

    typedef struct {
        logic m;
        int   t;
        int   c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   hold_left = 0;
    exp_t sb[$];
    logic [DW-1:0] term_m [int];
    int   cnt_m [int];
    int   pick [6] = '{3, 7, 7, 9, 7, 5};

    prm_edge_mask_engine_if #(.NUM_IN(NI), .NUM_EDGES(NE), .MAX_TERMS(MT)) bus ();

    prm_edge_mask_engine #(.NUM_IN(NI), .NUM_EDGES(NE), .MAX_TERMS(MT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: counts saturate, terms evaluated in order, first hit wins.
    task automatic model_cfg(input logic kind, input int e, input int t, input logic [DW-1:0] d);
        if (e >= int'(NE)) return;
        if (kind) cnt_m[e] = (d > DW'(MT)) ? int'(MT) : int'(d);
        else      term_m[e * int'(MT) + t] = d;
    endtask

    task automatic model_eval(input int e, input logic [NI-1:0] v, input int acc, output exp_t x);
        int    n;
        term_t w;
        n = cnt_m.exists(e) ? cnt_m[e] : 0;
        x.m = 1'b0;
        x.t = 0;
        for (int i = 0; i < n; i++) begin
            if (!x.m) begin
                w = term_m[e * int'(MT) + i];
                if (((v ^ w.value) & w.care) == '0) begin
                    x.m = 1'b1;
                    x.t = i;
                end
            end
        end
        x.c = acc + ((n == 0) ? 2 : (x.m ? 3 + x.t : 2 + n));
    endtask

    task automatic cfg_write(input logic kind, input int e, input int t, input logic [DW-1:0] d);
        bit fire = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_kind  = kind;
        bus.cfg_edge  = EW'(e);
        bus.cfg_term  = TW'(t);
        bus.cfg_data  = d;
        for (int k = 0; k < BUDGET && !fire; k++) begin
            fire = bus.cfg_ready;
            tick();
        end
        bus.cfg_valid = 1'b0;
        if (fire) model_cfg(kind, e, t, d);
        else      fail_now("cfg_accept");
    endtask

    task automatic prog_term(input int e, input int t, input logic [NI-1:0] care, input logic [NI-1:0] value);
        term_t w;
        w.care  = care;
        w.value = value;
        cfg_write(1'b0, e, t, w);
    endtask

    task automatic query(input int e, input logic [NI-1:0] v, input bit push, output int acc);
        bit   fire = 1'b0;
        exp_t x;
        acc = -1;
        bus.q_valid = 1'b1;
        bus.q_edge  = EW'(e);
        bus.q_vec   = v;
        for (int k = 0; k < BUDGET && !fire; k++) begin
            fire = bus.q_ready && !bus.cfg_valid;
            if (fire) acc = cyc;
            tick();
        end
        bus.q_valid = 1'b0;
        if (!fire) fail_now("q_accept");
        else if (push) begin
            model_eval(e, v, acc, x);
            sb.push_back(x);
        end
    endtask

    // Count write and query offered together: config first, query one cycle later.
    task automatic cfg_with_query(input int e, input logic [DW-1:0] cnt, input logic [NI-1:0] v);
        bit c_fire;
        int c_cyc, q_cyc;
        bus.cfg_valid = 1'b1;
        bus.cfg_kind  = 1'b1;
        bus.cfg_edge  = EW'(e);
        bus.cfg_term  = '0;
        bus.cfg_data  = cnt;
        bus.q_valid   = 1'b1;
        bus.q_edge    = EW'(e);
        bus.q_vec     = v;
        c_fire = bus.cfg_ready;
        c_cyc  = cyc;
        tick();
        bus.cfg_valid = 1'b0;
        check("cfg_q_cfg_taken", c_fire, 1);
        if (c_fire) model_cfg(1'b1, e, 0, cnt);
        query(e, v, 1'b1, q_cyc);
        check("cfg_q_query_cycle", q_cyc, c_cyc + 1);
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sb.size() != 0 || bus.r_valid) && k < BUDGET) begin
            tick();
            k++;
        end
        if (sb.size() != 0 || bus.r_valid) begin
            fail_now("drain");
            sb.delete();
        end
    endtask

    // Response-side backpressure: forced holds first, otherwise random.
    initial begin
        bus.r_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_left > 0 && bus.r_valid) begin
                bus.r_ready = 1'b0;
                hold_left--;
            end else begin
                bus.r_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: compare first response cycle against the scoreboard, then check it holds.
    initial begin
        bit            seen = 1'b0;
        logic          m_c = 1'b0;
        logic [TW-1:0] t_c = '0;
        exp_t          x;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (bus.r_valid) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_resp: r_valid with no query pending (cycle %0d)", cyc);
                    end else begin
                        x = sb.pop_front();
                        check("r_mask", bus.r_mask, x.m);
                        check("r_term", bus.r_term, x.t);
                        check("r_latency", cyc, x.c);
                    end
                    seen = 1'b1;
                    m_c  = bus.r_mask;
                    t_c  = bus.r_term;
                end else begin
                    check("hold_r_mask", bus.r_mask, m_c);
                    check("hold_r_term", bus.r_term, t_c);
                end
                check("resp_q_ready", bus.q_ready, 0);
                check("resp_cfg_ready", bus.cfg_ready, 0);
                if (bus.r_ready) seen = 1'b0;
            end
        end
    end

    initial begin
        #(950_000);
        $display("FAIL watchdog: run exceeded its time limit (cycle %0d)", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            a;
        logic [NI-1:0] v;
        bus.cfg_valid = 1'b0;
        bus.cfg_kind  = 1'b0;
        bus.cfg_edge  = '0;
        bus.cfg_term  = '0;
        bus.cfg_data  = '0;
        bus.q_valid   = 1'b0;
        bus.q_edge    = '0;
        bus.q_vec     = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_r_valid", bus.r_valid, 0);
        check("rst_r_mask", bus.r_mask, 0);
        check("rst_r_term", bus.r_term, 0);
        check("rst_cfg_ready", bus.cfg_ready, 0);
        check("rst_q_ready", bus.q_ready, 0);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_q_ready", bus.q_ready, 1);
        check("post_rst_cfg_ready", bus.cfg_ready, 1);

        // Unprogrammed edge answers 0 two cycles after acceptance.
        query(5, '0, 1'b1, a);
        wait_drain();

        // Two-term edge: miss then hit, hit on term 0, miss on both.
        prog_term(3, 0, 15'h0001, 15'h0000);
        prog_term(3, 1, 15'h4000, 15'h4000);
        cfg_write(1'b1, 3, 0, DW'(2));
        query(3, 15'h4001, 1'b1, a);
        query(3, 15'h0000, 1'b1, a);
        query(3, 15'h0001, 1'b1, a);
        wait_drain();

        // A care-free term matches any vector.
        prog_term(9, 0, 15'h7FFF, 15'h1234);
        prog_term(9, 1, 15'h0000, 15'h5555);
        cfg_write(1'b1, 9, 0, DW'(2));
        query(9, 15'h1234, 1'b1, a);
        query(9, 15'h0000, 1'b1, a);
        wait_drain();

        // Full-depth edge with saturating counts; only the last term can match 0x7FFF.
        for (int i = 0; i < int'(MT); i++)
            prog_term(11, i, 15'h7FFF, (i == int'(MT) - 1) ? 15'h7FFF : 15'h0000);
        cfg_write(1'b1, 11, 0, DW'(300));
        query(11, 15'h7FFF, 1'b1, a);
        query(11, 15'h0001, 1'b1, a);
        cfg_write(1'b1, 11, 0, '1);
        query(11, 15'h7FFF, 1'b1, a);
        query(11, 15'h0000, 1'b1, a);
        wait_drain();

        // Response held under backpressure.
        hold_left = 5;
        query(3, 15'h4001, 1'b1, a);
        wait_drain();

        // Large random SOP on edge 7, mixed with the smaller edges.
        for (int i = 0; i < 213; i++) begin
            if (i < 170) prog_term(7, i, NI'($urandom), NI'($urandom));
            else         prog_term(7, i, NI'($urandom & $urandom & $urandom), NI'($urandom));
        end
        cfg_write(1'b1, 7, 0, DW'(213));
        for (int n = 0; n < 400; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            v = NI'($urandom);
            query(pick[$urandom_range(0, 5)], v, 1'b1, a);
        end
        wait_drain();

        // Same-cycle config and query: the query must see the new count.
        prog_term(13, 0, 15'h0000, 15'h0000);
        cfg_with_query(13, DW'(1), NI'($urandom));
        wait_drain();

        // Reset in the middle of a long evaluation.
        for (int i = 0; i < 200; i++) prog_term(20, i, 15'h7FFF, 15'h0000);
        cfg_write(1'b1, 20, 0, DW'(200));
        query(20, 15'h7FFF, 1'b0, a);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_r_valid", bus.r_valid, 0);
        check("mid_rst_r_mask", bus.r_mask, 0);
        check("mid_rst_r_term", bus.r_term, 0);
        check("mid_rst_q_ready", bus.q_ready, 0);
        check("mid_rst_cfg_ready", bus.cfg_ready, 0);
        cnt_m.delete();
        term_m.delete();
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("rel_rst_q_ready", bus.q_ready, 1);
        check("rel_rst_cfg_ready", bus.cfg_ready, 1);
        query(20, 15'h7FFF, 1'b1, a);
        query(7, NI'($urandom), 1'b1, a);
        query(3, 15'h4001, 1'b1, a);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
